// File: rtl/seq_adder.sv
// seq_adder: bit-serial-by-chunk adder. An operation adds CHUNK bits per
// clock, least significant chunk first, over N = WIDTH/CHUNK BUSY cycles.
// The result is then held in DONE until the consumer takes it.
// WIDTH must be a positive multiple of CHUNK.
// Optional feature: define SEQ_ADDER_SUB_EN to honour the sub input
// (A-B via A + ~B + 1). Without it, every operation is A+B+CIN.
module seq_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
   logic [KW-1:0]    k_reg;
   logic             carry_reg, cout_reg, ovf_reg;

   logic [WIDTH-1:0] b_eff;
   logic             carry_eff;
   logic [CHUNK-1:0] a_cur, b_cur;
   logic [CHUNK:0]   chunk_sum;
   logic             last_chunk;
   logic             accept;

`ifdef SEQ_ADDER_SUB_EN
   // Subtraction is addition of the inverted operand with a forced carry-in.
   assign b_eff     = sub ? ~b : b;
   assign carry_eff = sub ? 1'b1 : cin;
`else
   logic unused_sub;
   assign b_eff      = b;
   assign carry_eff  = cin;
   assign unused_sub = sub;
`endif

   assign accept     = (state_reg == IDLE) && in_valid;
   assign last_chunk = (k_reg == KW'(N - 1));

   // Select the operand chunk addressed by the chunk index.
   always_comb begin
      a_cur = '0;
      b_cur = '0;
      for (int i = 0; i < N; i++) begin
         if (k_reg == KW'(i)) begin
            a_cur = a_reg[i*CHUNK +: CHUNK];
            b_cur = b_reg[i*CHUNK +: CHUNK];
         end
      end
   end

   assign chunk_sum = {1'b0, a_cur} + {1'b0, b_cur} + {{CHUNK{1'b0}}, carry_reg};

   // Only the active chunk's slice of the result changes; all others hold.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_slice
         assign sum_next[gi*CHUNK +: CHUNK] =
            ((state_reg == BUSY) && (k_reg == KW'(gi))) ? chunk_sum[CHUNK-1:0]
                                                         : sum_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   // Next-state and handshake outputs.
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = BUSY;
         end
         BUSY: begin
            if (last_chunk) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // Operand capture, per-chunk carry chain and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         k_reg     <= '0;
         carry_reg <= 1'b0;
         sum_reg   <= '0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         sum_reg <= sum_next;
         if (accept) begin
            a_reg     <= a;
            b_reg     <= b_eff;
            carry_reg <= carry_eff;
            k_reg     <= '0;
         end else if (state_reg == BUSY) begin
            carry_reg <= chunk_sum[CHUNK];
            k_reg     <= last_chunk ? '0 : k_reg + KW'(1);
            if (last_chunk) begin
               cout_reg <= chunk_sum[CHUNK];
               // Signed overflow: equal operand signs, result sign differs.
               ovf_reg  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (chunk_sum[CHUNK-1] != a_reg[WIDTH-1]);
            end
         end
      end
   end

   assign sum  = sum_reg;
   assign cout = cout_reg;
   assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder (WIDTH=32/CHUNK=8, plus a WIDTH=CHUNK=8 instance).
// Expectations follow SEQ_ADDER_SUB_EN when it is defined for the build.
module tb_seq_adder;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, sum;

   logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   seq_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
      .out_ready(out_ready8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   typedef struct {
      logic [31:0] va;
      logic [31:0] vb;
      logic        vcin;
      logic        vsub;
      logic [31:0] esum;
      logic        ecout;
      logic        eovf;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operation, wait (bounded) for the result, then consume it.
   // lat counts edges from the acceptance edge (inclusive) to out_valid.
   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic op_cin, input logic op_sub,
                         output logic [31:0] r_sum, output logic r_cout,
                         output logic r_ovf, output int lat);
      a = op_a; b = op_b; cin = op_cin; sub = op_sub; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      r_sum = sum; r_cout = cout; r_ovf = ovf;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r_sum;
      logic        r_cout, r_ovf;
      int          lat;

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

      vecs[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568, 1'b0, 1'b0};
      vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
      vecs[4] = '{32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0};
`ifdef SEQ_ADDER_SUB_EN
      vecs[5] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vecs[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0};
      vecs[7] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
`else
      vecs[5] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'h0000000C, 1'b0, 1'b0};
      vecs[6] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h0000000E, 1'b0, 1'b0};
      vecs[7] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h80000001, 1'b0, 1'b0};
`endif

      tick();
      tick();
      rst = 1'b0;
      check("reset_in_ready",  {31'b0, in_ready},  32'd1);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_sum",       sum,                32'd0);
      check("reset_cout",      {31'b0, cout},      32'd0);
      check("reset_ovf",       {31'b0, ovf},       32'd0);
      $display("reset: in_ready=%0b out_valid=%0b sum=0x%08h", in_ready, out_valid, sum);

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, r_sum, r_cout, r_ovf, lat);
         check("vec_sum",     r_sum,            vecs[i].esum);
         check("vec_cout",    {31'b0, r_cout},  {31'b0, vecs[i].ecout});
         check("vec_ovf",     {31'b0, r_ovf},   {31'b0, vecs[i].eovf});
         check("vec_latency", 32'(lat),         32'(N + 1));
         $display("vec %0d: a=0x%08h b=0x%08h cin=%0b sub=%0b -> sum=0x%08h cout=%0b ovf=%0b lat=%0d",
                  i, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, r_sum, r_cout, r_ovf, lat);
      end

      // Back-pressure in DONE with stray in_valid pulses in BUSY and DONE.
      a = 32'h11111111; b = 32'h22222222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      tick();
      a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 2;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("hold_latency", 32'(lat), 32'(N + 1));
      in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("hold_out_valid", {31'b0, out_valid}, 32'd1);
         check("hold_sum",       sum,                32'h33333333);
         check("hold_cout",      {31'b0, cout},      32'd0);
         check("hold_ovf",       {31'b0, ovf},       32'd0);
      end
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_in_ready",  {31'b0, in_ready},  32'd1);
      check("release_out_valid", {31'b0, out_valid}, 32'd0);
      check("idle_sum_held",     sum,                32'h33333333);
      tick();
      tick();
      check("no_queued_op", {31'b0, in_ready & ~out_valid}, 32'd1);
      $display("backpressure: sum=0x%08h in_ready=%0b", sum, in_ready);

      // Reset during the second BUSY cycle aborts the operation.
      a = 32'hAAAAAAAA; b = 32'h11111111; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_in_ready",  {31'b0, in_ready},  32'd1);
      check("abort_out_valid", {31'b0, out_valid}, 32'd0);
      check("abort_sum",       sum,                32'd0);
      check("abort_cout",      {31'b0, cout},      32'd0);
      lat = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid) lat++;
      end
      check("abort_no_result", 32'(lat), 32'd0);
      run_op(32'd3, 32'd4, 1'b0, 1'b0, r_sum, r_cout, r_ovf, lat);
      check("after_abort_sum",     r_sum,     32'h00000007);
      check("after_abort_latency", 32'(lat),  32'(N + 1));
      $display("abort: post-reset op 3+4 -> sum=0x%08h lat=%0d", r_sum, lat);

      // Single-chunk configuration: latency 2.
      a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
      tick();
      in_valid8 = 1'b0;
      lat = 1;
      while (!out_valid8 && lat < 20) begin
         tick();
         lat++;
      end
      check("n1_latency", 32'(lat),          32'd2);
      check("n1_sum",     {24'b0, sum8},     32'h00000000);
      check("n1_cout",    {31'b0, cout8},    32'd1);
      check("n1_ovf",     {31'b0, ovf8},     32'd0);
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
      check("n1_in_ready", {31'b0, in_ready8}, 32'd1);
      $display("n1: 0xff+0x01 -> sum=0x%02h cout=%0b lat=%0d", sum8, cout8, lat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8, bits added per clock cycle; N = WIDTH/CHUNK cycles per operation.
REQ-003 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 IN_VALID  input  1  operands valid.
REQ-006 IN_READY  output  1  block can accept operands.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 CIN  input  1  carry-in; add mode only.
REQ-010 SUB  input  1  1 = A-B, 0 = A+B+CIN; active only with SEQ_ADDER_SUB_EN.
REQ-011 OUT_VALID  output  1  result valid.
REQ-012 OUT_READY  input  1  consumer accepts result.
REQ-013 SUM  output  WIDTH  result.
REQ-014 COUT  output  1  carry out of MSB; in subtract mode 1 = no borrow.
REQ-015 OVF  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states: IDLE, BUSY, DONE; IN_READY SHALL be 1 only in IDLE; OUT_VALID SHALL be 1 only in DONE.
REQ-017 IDLE: on IN_VALID=1, register A, B_eff, carry_eff, clear chunk index k, go to BUSY; otherwise stay.
REQ-018 Add mode: B_eff = B, carry_eff = CIN; subtract mode: B_eff = ~B, carry_eff = 1, CIN ignored.
REQ-019 BUSY: each cycle add chunk k (bits k*CHUNK+CHUNK-1 .. k*CHUNK, LSB chunk first) plus registered carry, write that SUM slice, register carry-out, increment k.
REQ-020 After chunk N-1 completes, go to DONE with COUT = final carry and OVF = (A[MSB] == B_eff[MSB]) && (SUM[MSB] != A[MSB]).
REQ-021 Latency: operands accepted at edge E; OUT_VALID SHALL rise exactly N+1 edges after E (N BUSY cycles).
REQ-022 DONE: SUM, COUT, OVF SHALL be held stable while OUT_READY=0; on OUT_READY=1, go to IDLE; IN_READY rises the following cycle.
REQ-023 IN_VALID, A, B, CIN, SUB SHALL be ignored in BUSY and DONE; no operation is queued or overlapped.
REQ-024 Arithmetic is modulo 2^WIDTH; WIDTH=CHUNK (N=1) SHALL be legal and give latency 2.
REQ-025 SUM, COUT, OVF SHALL hold their last values in IDLE until the next operation overwrites them.

Reset
REQ-026 RST=1 at an edge SHALL force IDLE, k=0, carry=0, SUM=0, COUT=0, OVF=0, OUT_VALID=0, IN_READY=1, overriding all other inputs.
REQ-027 RST asserted in BUSY or DONE SHALL abort the operation with no result delivered.

Configuration
REQ-028 Macro SEQ_ADDER_SUB_EN defined: SUB input is honoured per REQ-018.
REQ-029 Macro SEQ_ADDER_SUB_EN undefined: subtraction logic is not compiled in, SUB is ignored, and every operation is A+B+CIN; port list is unchanged.

Verification (WIDTH=32, CHUNK=8, macro defined unless stated)
REQ-030 A=0xFFFFFFFF, B=0x00000000, CIN=1, SUB=0 -> SUM=0x00000000, COUT=1, OVF=0, OUT_VALID exactly 5 edges after acceptance.
REQ-031 A=0x7FFFFFFF, B=0x00000001, CIN=0, SUB=0 -> SUM=0x80000000, COUT=0, OVF=1.
REQ-032 A=5, B=7, SUB=1, CIN=0 -> SUM=0xFFFFFFFE, COUT=0, OVF=0; same stimulus with macro undefined -> SUM=0x0000000C.
REQ-033 OUT_READY held 0 for 3 cycles in DONE -> SUM/COUT/OVF/OUT_VALID unchanged; IN_VALID pulses during BUSY/DONE are ignored; IN_READY=1 one cycle after OUT_READY=1.
REQ-034 RST=1 during 2nd BUSY cycle -> next cycle IDLE, IN_READY=1, OUT_VALID=0, SUM=0; a new operation 3+4 then yields SUM=0x00000007.
